aes_inv_key_schedule: RTL
=========================

Name: aes_inv_key_schedule

Overview:
- Decryption-side AES-128 key schedule.
- On `kld` it latches the 128-bit cipher key and runs the forward expansion internally for 10 cycles to reach round key 10.
- It then walks the schedule backwards, presenting round keys 10, 9, ..., 0 one at a time over a valid/ready handshake.
- It feeds the inverse-cipher round datapath, which consumes round keys in reverse order.

Parameters:
- NR, 10, number of AES rounds; fixed at 10 for AES-128, and other values are unsupported.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- kld  in  1  key load strobe; samples `key` on the same edge.
- key  in  128  cipher key; `[127:96]` is w0 and `[31:0]` is w3.
- busy  out  1  high while in EXPAND or EMIT.
- rk_valid  out  1  `rk` / `rk_idx` / `rk_last` are valid.
- rk_ready  in  1  consumer accepts the current round key.
- rk  out  128  round key, same word ordering as `key`.
- rk_idx  out  4  round number of `rk`, from 10 down to 0.
- rk_last  out  1  high with `rk_valid` when `rk_idx` is 0.

Behaviour:
- State register: w0..w3, four 32-bit words; `rk = {w0,w1,w2,w3}`.
- Round counter `rnd`: 4 bits.
- FSM states: IDLE, EXPAND, EMIT.
- Reset (`rst` = 1 at a clk edge):
  - state goes to IDLE; `rnd` = 0; w0..w3 = 0.
  - `rk_valid` = 0, `busy` = 0, `rk_idx` = 0, `rk_last` = 0.
  - `rst` overrides `kld`.
- `kld` behaviour (`rst` = 0):
  - Accepted in any state. A `kld` in EXPAND or EMIT aborts the current schedule and restarts.
  - `kld` wins over a simultaneous `rk_valid & rk_ready`; that handshake is not counted.
  - Effect: w <= key, `rnd` <= 1, state goes to EXPAND.
- EXPAND, one forward step per cycle:
  - `t = SubWord(RotWord(w3)) ^ {rcon(rnd), 24'h0}`.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - After the step with `rnd` = 10, go to EMIT with `rnd` = 10. Otherwise increment `rnd`.
- Latency: `kld` sampled at edge 0 → `rk_valid` = 1 with `rk_idx` = 10 after edge 10. That is 10 EXPAND cycles, and round key 10 is visible in the cycle following edge 10.
- EMIT:
  - `rk_valid` = 1, `rk_idx` = `rnd`, `rk_last` = (`rnd` == 0).
  - While `rk_ready` = 0, `rk` / `rk_idx` are held stable and `rk_valid` is not dropped.
  - On `rk_valid & rk_ready` with `rnd` > 0, apply one inverse step:
    - w3p = w3^w2; w2p = w2^w1; w1p = w1^w0.
    - w0p = w0 ^ SubWord(RotWord(w3p)) ^ {rcon(rnd), 24'h0}.
    - Then `rnd` <= `rnd` − 1.
  - On the handshake with `rnd` = 0: go to IDLE and drop `rk_valid` the next cycle. w retains round key 0, which equals `key`.
- Throughput: one round key per cycle when `rk_ready` is held high; 11 handshakes per load.
- IDLE: `rk_valid` = 0, `busy` = 0. `rk_ready` is ignored.
- rcon(1..10) = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. rcon for `rnd` 0 or 11–15 = 00 (unreachable).
- S-box sharing:
  - A single bank of four S-boxes is shared by EXPAND and EMIT.
  - Its input is muxed: w3 in EXPAND, w3p in EMIT.
  - The byte order is RotWord: S-box inputs are bytes `[23:16]`, `[15:8]`, `[7:0]`, `[31:24]`, feeding output bytes `[31:24]` down to `[7:0]`.
- The S-box path is combinational; no additional pipeline registers.
- Width rules: all XOR is bitwise 32-bit; there is no arithmetic beyond the `rnd` increment/decrement, which never wraps in legal operation.

Decomposition:
- `aes_pkg`: `AES_NR` = 10, the rcon table as a function `aes_rcon_byte(rnd)`, and the FSM state enum {IDLE, EXPAND, EMIT}.
- Reuse the existing `aes_sbox` module (4 instances).
- One natural sub-module: `aes_key_word_mix`, combinational, holding the shared RotWord+SubWord+rcon function. Inputs: a 32-bit word and `rnd`. Output: `t`.

Test Plan:
- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`, `kld` 1 cycle, `rk_ready` = 1:
  - `rk_valid` rises exactly 10 cycles after the `kld` edge, with `rk` = `d014f9a8c9ee2589e13f0cc8b6630ca6` and `rk_idx` = 10.
  - Then 11 consecutive keys; `rk_idx` = 1 gives `a0fafe1788542cb123a339392a6c7605`.
  - `rk_idx` = 0 gives the original key with `rk_last` = 1, then `busy` = 0.
- Backpressure: `rk_ready` = 0 for 5 cycles at `rk_idx` = 7 → `rk` / `rk_idx` stable and `rk_valid` held; the sequence resumes unchanged. Random `rk_ready` toggling gives the same 11 keys in the same order.
- Abort: `kld` with key `000102030405060708090a0b0c0d0e0f` during EMIT at `rk_idx` = 4 → the handshake is not counted, `rk_valid` = 0 next cycle. Ten cycles later: `rk` = `13111d7fe3944a17f307a78b4d2b30c5`, `rk_idx` = 10.
- Reset mid-EXPAND (cycle 5) → next cycle `busy` = 0, `rk_valid` = 0, `rk` = 0. A subsequent `kld` behaves exactly as from power-up.
- `rst` and `kld` asserted on the same edge → IDLE, no load.
- All-zero key → `rk_idx` = 10 gives `b4ef5bcb3e92e21123e951cf6f8f188e`; `rk_idx` = 0 gives all zero.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key schedule blocks: round count,
// round-constant table and the schedule FSM state encoding.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        EMIT
    } ks_state_e;

    // Round constant high byte. Rounds 0 and 11-15 are never used and give 0.
    function automatic logic [7:0] aes_rcon_byte(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_word_mix.sv
// Key-schedule word function: SubWord(RotWord(w)) ^ {rcon(rnd), 24'h0}.
// Holds the single bank of four S-boxes shared by both schedule directions.
module aes_key_word_mix
    import aes_pkg::*;
(
    input  logic [31:0] w,
    input  logic [3:0]  rnd,
    output logic [31:0] t
);

    logic [31:0] rot_w;
    logic [31:0] sub_w;

    assign rot_w = {w[23:0], w[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .din  (rot_w[gi*8 +: 8]),
                .dout (sub_w[gi*8 +: 8])
            );
        end
    endgenerate

    assign t = sub_w ^ {aes_rcon_byte(rnd), 24'h000000};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, computed as GF(2^8) inverse (x^254) followed by the
// affine transform, so no table has to be maintained by hand.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 = product of x^2, x^4, ..., x^128; maps 0 to 0 as required.
    always_comb begin
        sq  = din;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
    end

    assign dout = inv
                ^ {inv[6:0], inv[7]}
                ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]}
                ^ 8'h63;

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 decryption key schedule: expands forward to round key 10, then
// walks back and hands out round keys 10..0 over a valid/ready handshake.
module aes_inv_key_schedule
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         rk_last
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    ks_state_e         state_reg, state_next;
    logic [3:0]        rnd_reg, rnd_next;
    logic [0:3][31:0]  w_reg, w_next;
    logic [0:3][31:0]  w_fwd;
    logic [0:3][31:0]  w_inv;
    logic [31:0]       mix_in;
    logic [31:0]       mix_t;

    // Inverse step: words 1..3 of the previous round key need no S-box.
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_inv
            assign w_inv[gi] = w_reg[gi] ^ w_reg[gi-1];
        end
    endgenerate
    assign w_inv[0] = w_reg[0] ^ mix_t;

    // The shared S-box bank sees w3 going forward and the recovered w3 going back.
    assign mix_in = (state_reg == EMIT) ? w_inv[3] : w_reg[3];

    aes_key_word_mix u_mix (
        .w   (mix_in),
        .rnd (rnd_reg),
        .t   (mix_t)
    );

    always_comb begin
        w_fwd[0] = w_reg[0] ^ mix_t;
        w_fwd[1] = w_reg[1] ^ w_fwd[0];
        w_fwd[2] = w_reg[2] ^ w_fwd[1];
        w_fwd[3] = w_reg[3] ^ w_fwd[2];
    end

    always_comb begin
        state_next = state_reg;
        rnd_next   = rnd_reg;
        w_next     = w_reg;
        if (kld) begin
            // A load restarts from any state and swallows a coincident handshake.
            state_next = EXPAND;
            rnd_next   = 4'd1;
            w_next     = key;
        end else begin
            case (state_reg)
                IDLE: begin
                end
                EXPAND: begin
                    w_next = w_fwd;
                    if (rnd_reg == LAST_RND) begin
                        state_next = EMIT;
                    end else begin
                        rnd_next = rnd_reg + 4'd1;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (rnd_reg != 4'd0) begin
                            w_next   = w_inv;
                            rnd_next = rnd_reg - 4'd1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rnd_reg   <= 4'd0;
            w_reg     <= '0;
        end else begin
            state_reg <= state_next;
            rnd_reg   <= rnd_next;
            w_reg     <= w_next;
        end
    end

    assign busy     = (state_reg != IDLE);
    assign rk_valid = (state_reg == EMIT);
    assign rk_idx   = rk_valid ? rnd_reg : 4'd0;
    assign rk_last  = rk_valid && (rnd_reg == 4'd0);
    assign rk       = w_reg;

endmodule
